// File: rtl/ex_muldiv_pkg.sv
// Shared RV32M constants: operand width, M-extension encodings and the
// iterative unit's state type, used by the decoder and the mul/div unit.
package ex_muldiv_pkg;

  localparam int WORD = 32;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  // Two's complement of a word when neg is set, pass-through otherwise.
  function automatic logic [WORD-1:0] neg_if(input logic neg, input logic [WORD-1:0] v);
    return neg ? ((~v) + {{(WORD-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Shared accumulator datapath: one shift-add multiply step or one restoring
// divide step per cycle, plus the sign fix-up and result selection applied
// to the value the accumulator is about to take.
module ex_muldiv_core
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             mul_step,
  input  logic             div_step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       func3,
  input  logic             neg_prod,
  input  logic             neg_quo,
  input  logic             neg_rem,
  output logic [WIDTH-1:0] result_next
);

  // acc: MUL -> {partial product high, multiplier/product low}
  //      DIV -> {partial remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Next accumulator value for a multiply or divide step, and the fixed-up result.
  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    mul_next  = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    // Remainder never exceeds the divisor, so shifting in one bit fits in WIDTH+1.
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    sub_diff  = rem_shift - {1'b0, opb};
    if (sub_diff[WIDTH]) begin
      div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
    if (mul_step) begin
      acc_next = mul_next;
    end else if (div_step) begin
      acc_next = div_next;
    end else begin
      acc_next = acc;
    end
    prod_fix = neg_prod ? ((~acc_next) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_next;
    quo_fix  = neg_if(neg_quo, acc_next[WIDTH-1:0]);
    rem_fix  = neg_if(neg_rem, acc_next[2*WIDTH-1:WIDTH]);
    case (func3)
      F3_MUL:                     result_next = prod_fix[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_next = prod_fix[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:            result_next = quo_fix;
      F3_REM, F3_REMU:            result_next = rem_fix;
      default:                    result_next = {WIDTH{1'b0}};
    endcase
  end

  // Accumulator and second operand: loaded at launch, advanced on each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= {(2*WIDTH){1'b0}};
      opb <= {WIDTH{1'b0}};
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, op_a};
      opb <= op_b;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage iterative RV32M multiply/divide unit. Stalls the front of the
// pipeline while iterating and presents the result for one cycle in DONE.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = WORD
) (
  input  logic             CLK_i,
  input  logic             RSTn_i,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [2:0]       func3_i,
  input  logic [WIDTH-1:0] dataSrc1_i,
  input  logic [WIDTH-1:0] dataSrc2_i,
  input  logic [4:0]       regDest_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       regDest_o
);

  md_state_t        state;
  logic [4:0]       cnt;
  logic [2:0]       func3_q;
  logic [4:0]       rd_q;
  logic             neg_prod_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             valid_q;

  logic             launch;
  logic             s1_signed;
  logic             s2_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] special_result;
  logic [WIDTH-1:0] result_next;

  // Launch decode: operand signedness, magnitudes and the no-iteration cases.
  always_comb begin
    launch    = (state == ST_IDLE) && start_i && !flush_i;
    s1_signed = (func3_i == F3_MULH) || (func3_i == F3_MULHSU) ||
                (func3_i == F3_DIV)  || (func3_i == F3_REM);
    s2_signed = (func3_i == F3_MULH) || (func3_i == F3_DIV) || (func3_i == F3_REM);
    a_neg     = s1_signed && dataSrc1_i[WIDTH-1];
    b_neg     = s2_signed && dataSrc2_i[WIDTH-1];
    a_mag     = neg_if(a_neg, dataSrc1_i);
    b_mag     = neg_if(b_neg, dataSrc2_i);
    div_zero  = func3_i[2] && (dataSrc2_i == {WIDTH{1'b0}});
    div_ovf   = ((func3_i == F3_DIV) || (func3_i == F3_REM)) &&
                (dataSrc1_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
                (dataSrc2_i == {WIDTH{1'b1}});
    if (div_zero) begin
      special_result = func3_i[1] ? dataSrc1_i : {WIDTH{1'b1}};
    end else if (div_ovf) begin
      special_result = func3_i[1] ? {WIDTH{1'b0}} : {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      special_result = {WIDTH{1'b0}};
    end
  end

  // Stall is gated by reset and flush so neither can hold the pipeline.
  always_comb begin
    stall_o = RSTn_i && !flush_i &&
              (((state == ST_IDLE) && start_i) || (state == ST_MUL) || (state == ST_DIV));
    // A flush arriving in DONE kills the strobe before EX/MEM can capture it.
    valid_o = valid_q && !flush_i;
  end

  ex_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk         (CLK_i),
    .rst_n       (RSTn_i),
    .load        (launch),
    .mul_step    ((state == ST_MUL) && !flush_i),
    .div_step    ((state == ST_DIV) && !flush_i),
    .op_a        (a_mag),
    .op_b        (b_mag),
    .func3       (func3_q),
    .neg_prod    (neg_prod_q),
    .neg_quo     (neg_quo_q),
    .neg_rem     (neg_rem_q),
    .result_next (result_next)
  );

  // Control FSM with iteration counter, latched op info and registered outputs.
  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state      <= ST_IDLE;
      cnt        <= 5'd0;
      func3_q    <= 3'd0;
      rd_q       <= 5'd0;
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      valid_q    <= 1'b0;
      result_o   <= {WIDTH{1'b0}};
      regDest_o  <= 5'd0;
    end else if (flush_i) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            func3_q    <= func3_i;
            rd_q       <= regDest_i;
            cnt        <= 5'd0;
            neg_prod_q <= a_neg ^ b_neg;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            if (div_zero || div_ovf) begin
              state     <= ST_DONE;
              valid_q   <= 1'b1;
              result_o  <= special_result;
              regDest_o <= regDest_i;
            end else begin
              state   <= func3_i[2] ? ST_DIV : ST_MUL;
              valid_q <= 1'b0;
            end
          end else begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        ST_MUL, ST_DIV: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state     <= ST_DONE;
            valid_q   <= 1'b1;
            result_o  <= result_next;
            regDest_o <= rd_q;
          end else begin
            valid_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: expected results are queued at launch and
// compared when valid_o strobes; latency and stall length are checked per op.
module tb_ex_muldiv;

  logic        CLK_i;
  logic        RSTn_i;
  logic        flush_i;
  logic        start_i;
  logic [2:0]  func3_i;
  logic [31:0] dataSrc1_i;
  logic [31:0] dataSrc2_i;
  logic [4:0]  regDest_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  regDest_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] sb_q[$];
  logic prev_valid = 1'b0;

  ex_muldiv #(.WIDTH(32)) dut (
    .CLK_i      (CLK_i),
    .RSTn_i     (RSTn_i),
    .flush_i    (flush_i),
    .start_i    (start_i),
    .func3_i    (func3_i),
    .dataSrc1_i (dataSrc1_i),
    .dataSrc2_i (dataSrc2_i),
    .regDest_i  (regDest_i),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .regDest_o  (regDest_o)
  );

  initial CLK_i = 1'b0;
  always #5 CLK_i = ~CLK_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge CLK_i) begin
    logic [36:0] e;
    if (valid_o) begin
      check_eq("no_consec_valid", {63'd0, prev_valid}, 64'd0);
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", {32'd0, result_o}, 64'd0);
        check_eq("unexpected_valid_flag", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("result", {32'd0, result_o}, {32'd0, e[31:0]});
        check_eq("regdest", {59'd0, regDest_o}, {59'd0, e[36:32]});
      end
    end
    prev_valid = valid_o;
  end

  // Present an op to the unit (call just after a rising edge; that cycle is cycle 0).
  task automatic drive_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit push);
    start_i    = 1'b1;
    func3_i    = f;
    dataSrc1_i = a;
    dataSrc2_i = b;
    regDest_i  = rd;
    if (push) sb_q.push_back({rd, exp});
  endtask

  // Wait (bounded) for the strobe; check its cycle and the stall length.
  task automatic wait_done(input string tag, input int exp_cyc);
    int got_cyc;
    int stalls;
    got_cyc = -1;
    stalls  = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK_i);
      if (stall_o) stalls++;
      if (valid_o) begin
        got_cyc = c;
        break;
      end
    end
    check_eq({tag, "_valid_cycle"}, 64'(got_cyc), 64'(exp_cyc));
    check_eq({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_cyc));
    @(posedge CLK_i);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_cyc);
    @(posedge CLK_i);
    #1;
    drive_op(f, a, b, rd, exp, 1'b1);
    wait_done(tag, exp_cyc);
    start_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    RSTn_i = 1'b0; flush_i = 1'b0; start_i = 1'b0;
    func3_i = 3'd0; dataSrc1_i = 32'd0; dataSrc2_i = 32'd0; regDest_i = 5'd0;
    #12;
    check_eq("rst_valid", {63'd0, valid_o}, 64'd0);
    check_eq("rst_stall", {63'd0, stall_o}, 64'd0);
    check_eq("rst_result", {32'd0, result_o}, 64'd0);
    check_eq("rst_rd", {59'd0, regDest_o}, 64'd0);
    @(negedge CLK_i);
    RSTn_i = 1'b1;

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33);
    run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 33);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 33);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
    run_op("divu",   3'b101, 32'd100,      32'd7,        5'd7,  32'h0000000E, 33);
    run_op("remu",   3'b111, 32'd100,      32'd7,        5'd8,  32'h00000002, 33);
    run_op("div0",   3'b100, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1);
    run_op("remu0",  3'b111, 32'd5,        32'd0,        5'd10, 32'd5,        1);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1);

    // Flush in cycle 10 of a DIV: nothing queued, so any strobe is an error.
    @(posedge CLK_i); #1;
    drive_op(3'b100, 32'd100, 32'd7, 5'd13, 32'd0, 1'b0);
    repeat (10) @(posedge CLK_i);
    #1;
    flush_i = 1'b1;
    @(negedge CLK_i);
    check_eq("flush_stall", {63'd0, stall_o}, 64'd0);
    check_eq("flush_valid", {63'd0, valid_o}, 64'd0);
    @(posedge CLK_i); #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    @(negedge CLK_i);
    check_eq("post_flush_stall", {63'd0, stall_o}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge CLK_i);
      if (valid_o || stall_o) seen++;
    end
    check_eq("flush_no_activity", 64'(seen), 64'd0);

    // Asynchronous reset in cycle 20 of a MUL.
    @(posedge CLK_i); #1;
    drive_op(3'b000, 32'd9, 32'd9, 5'd14, 32'd0, 1'b0);
    repeat (20) @(posedge CLK_i);
    #2;
    RSTn_i  = 1'b0;
    start_i = 1'b0;
    #1;
    check_eq("arst_valid", {63'd0, valid_o}, 64'd0);
    check_eq("arst_stall", {63'd0, stall_o}, 64'd0);
    check_eq("arst_result", {32'd0, result_o}, 64'd0);
    check_eq("arst_rd", {59'd0, regDest_o}, 64'd0);
    @(negedge CLK_i);
    RSTn_i = 1'b1;
    run_op("mul_after_rst", 3'b000, 32'd11, 32'd13, 5'd15, 32'd143, 33);

    // Back-to-back MULs: second launch in cycle 34, its strobe in cycle 67.
    @(posedge CLK_i); #1;
    drive_op(3'b000, 32'd3, 32'd4, 5'd16, 32'h0000000C, 1'b1);
    wait_done("b2b_first", 33);
    drive_op(3'b000, 32'd5, 32'd6, 5'd17, 32'h0000001E, 1'b1);
    wait_done("b2b_second", 33);
    start_i = 1'b0;

    repeat (3) @(negedge CLK_i);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Execute-stage iterative RV32M multiply/divide unit, fed directly by the ID/EX pipeline register outputs: forwarded operands, func3, destination register. It runs MUL/MULH/MULHSU/MULHU with 32-step shift-add and DIV/DIVU/REM/REMU with 32-step restoring division. While an operation is in flight it asserts `stall_o` to freeze PC, IF/ID and ID/EX. It then presents the 32-bit result for one cycle to the EX/MEM latch.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `CLK_i`  in  1  single clock; all state updates on the rising edge.
- `RSTn_i`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  kills any in-flight operation; has priority over `start_i`.
- `start_i`  in  1  ID/EX holds an M-extension op (opcode OP, funct7 = 0000001).
- `func3_i`  in  3  selects the op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `dataSrc1_i`  in  WIDTH  rs1 operand, already forwarded.
- `dataSrc2_i`  in  WIDTH  rs2 operand, already forwarded.
- `regDest_i`  in  5  rd of the op.
- `stall_o`  out  1  combinational; holds the upstream pipeline.
- `valid_o`  out  1  registered; one-cycle result strobe.
- `result_o`  out  WIDTH  registered result; valid only while `valid_o` = 1.
- `regDest_o`  out  5  registered rd; accompanies `valid_o`.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. All registers reset to 0, state to IDLE.
- **Launch (IDLE, `start_i` = 1, `flush_i` = 0):**
  - Latch op, rd, operand magnitudes and result-sign flag. Clear the 5-bit iteration counter.
  - Signed operands: MULH uses rs1 and rs2; MULHSU uses rs1 only; DIV/REM use both.
  - Go to MUL for func3[2] = 0, otherwise DIV.
- **MUL:** 64-bit accumulator. Each cycle: if the multiplier LSB is 1, add the multiplicand to the upper half. Then shift right one bit.
- **DIV:** 33-bit partial remainder. Each cycle: shift in the next dividend bit; if remainder − divisor ≥ 0, subtract and set the quotient bit.
- **Finishing:** leave MUL/DIV when the counter reaches 31, going to DONE. In DONE:
  - Apply sign correction: two's complement of the 64-bit product or the quotient when the sign flag is set. The remainder takes the dividend's sign.
  - Select the result: MUL = low word; MULH/MULHSU/MULHU = high word; DIV/DIVU = quotient; REM/REMU = remainder.
  - Assert `valid_o`.
- **DONE → IDLE unconditionally.** `start_i` is ignored in DONE (it still reflects the completing op).
- **Special cases, resolved at launch with no iterations (go straight to DONE):**
  - Divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV/REM with 0x80000000 ÷ 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- **`flush_i` = 1 in any state:**
  - Next state is IDLE and `valid_o` stays 0.
  - A flush in DONE suppresses that strobe.
  - `stall_o` is 0 during the flush cycle.
- **Asynchronous reset mid-operation:** state goes to IDLE; `valid_o`, `result_o`, `regDest_o` go to 0 immediately and `stall_o` goes to 0. No result is produced.

## Timing
- Cycle 0 is the IDLE cycle in which `start_i` is first sampled high.
- `stall_o` = (IDLE ∧ `start_i` ∧ ¬`flush_i`) ∨ MUL ∨ DIV.
- **Normal op:**
  - Iterations run in cycles 1–32; DONE is cycle 33.
  - `stall_o` is high for cycles 0–32 (33 cycles).
  - `valid_o`/`result_o` are visible in cycle 33, and EX/MEM captures them at the end of cycle 33.
- **Special case:** DONE is cycle 1; `stall_o` is high only in cycle 0.
- **Ordering:** ID/EX advances at the end of DONE, so a back-to-back M-op is sampled in IDLE at cycle 34. There is no zero-gap pipelining.
- `valid_o` is never high for two consecutive cycles.

## Structure
- The shared constants header carries the func3 encodings for the eight M ops, the M funct7 value and the `WORD` width macro. The decoder and this block both use them.
- One sub-module, `ex_muldiv_core`: the accumulator/remainder datapath with shift, add/subtract and sign fix-up, controlled by the FSM and counter in `ex_muldiv`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `result_o` = 0xFFFFFFEB, `valid_o` in cycle 33 only, `stall_o` high cycles 0–32.
- MULHU, MULH, MULHSU each with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE, 0x00000000, 0xFFFFFFFF respectively; `regDest_o` equals the launched rd.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002.
- Special cases, each with `valid_o` in cycle 1 and `stall_o` high one cycle:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Abort cases:
  - `flush_i` pulsed in cycle 10 of a DIV → IDLE in cycle 11, no `valid_o`, `stall_o` low.
  - `RSTn_i` low in cycle 20 of a MUL → all outputs 0 asynchronously; the next op after reset completes normally.
- Two back-to-back MULs (3×4 then 5×6) → 0x0000000C in cycle 33, second launch at cycle 34, 0x0000001E in cycle 67.
